edge_frame_sequencer: RTL

Pixel-domain controller that sequences the Sobel edge-detection datapath for each video frame. It locks to the input frame using VSYNC and DE, and tracks the active pixel column and row. It issues one start pulse per pixel that has a complete 3x3 window, and flags when the Sobel core overruns. It also generates a delayed vertical-reset pulse for the output timing generator, so that regenerated syncs line up with processed data.

---
 rtl/edge_frame_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/edge_frame_sequencer.sv
// Sequencer for the Sobel edge-detection datapath, running in the pixel clock domain.
// It locks to the input frame on a VSYNC rising edge and follows the active column and row
// on DE. It issues one start pulse for each pixel that has a complete 3x3 window and records
// sticky error flags for bad frame geometry, short lines and Sobel overrun. It also generates
// a delayed vertical-reset pulse for the output timing generator.
//
// Ports:
//   I_CLK        pixel clock
//   I_RST        synchronous active-high reset
//   I_ENABLE     sequencer enable; low forces IDLE
//   I_VSYNC      input vertical sync, active-high
//   I_DE         input data enable
//   I_DONE       Sobel result-complete pulse
//   I_CLR_ERR    clears the sticky error flags (a set in the same cycle wins)
//   O_COL/O_ROW  position of the pixel qualified by O_PIX_VALID
//   O_PIX_VALID  registered DE sample counted while locked
//   O_START      Sobel start pulse, aligned with O_PIX_VALID
//   O_VRST       one-cycle pulse VRST_DLY cycles after a VSYNC rise
//   O_LOCKED     high while in FRAME
//   O_FRAME_CNT  completed good frames, wrapping
//   O_ERR_FRAME  sticky: wrong line count or an extra line
//   O_ERR_LINE   sticky: DE dropped mid-line
//   O_OVERRUN    sticky: start issued while the Sobel core was still busy
module edge_frame_sequencer #(
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned ROW_W    = 9,
    parameter int unsigned VRST_DLY = 1602,
    parameter int unsigned DLY_W    = 12
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_ENABLE,
    input  logic             I_VSYNC,
    input  logic             I_DE,
    input  logic             I_DONE,
    input  logic             I_CLR_ERR,
    output logic [COL_W-1:0] O_COL,
    output logic [ROW_W-1:0] O_ROW,
    output logic             O_PIX_VALID,
    output logic             O_START,
    output logic             O_VRST,
    output logic             O_LOCKED,
    output logic [7:0]       O_FRAME_CNT,
    output logic             O_ERR_FRAME,
    output logic             O_ERR_LINE,
    output logic             O_OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_FRAME     = 2'd2
    } state_t;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(VRST_DLY);
    localparam logic             VRST_NOW = (VRST_DLY == 32'd1);

    state_t             state_q;
    logic               vs_q, de_q, busy_q;
    logic [COL_W-1:0]   col_q, col_o_q;
    logic [ROW_W-1:0]   row_q, row_o_q;
    logic [DLY_W-1:0]   dly_q;
    logic               pv_q, start_q, vrst_q, locked_q;
    logic [7:0]         frame_cnt_q;
    logic               err_frame_q, err_line_q, overrun_q;

    logic vs_rise, de_fall, line_end, frame_done, extra_line, short_line;

    // Edge detects and geometry qualifiers on the live counters
    assign vs_rise    = I_VSYNC & ~vs_q;
    assign de_fall    = de_q & ~I_DE;
    assign line_end   = (col_q == COL_W'(H_ACT - 1));
    assign frame_done = (row_q == ROW_W'(V_ACT)) && (col_q == '0);
    assign extra_line = I_DE && (row_q == ROW_W'(V_ACT));
    assign short_line = de_fall && (col_q != '0);

    // FSM, counters, delay timer and flags
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q     <= ST_IDLE;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            busy_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            col_o_q     <= '0;
            row_o_q     <= '0;
            dly_q       <= '0;
            pv_q        <= 1'b0;
            start_q     <= 1'b0;
            vrst_q      <= 1'b0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_frame_q <= 1'b0;
            err_line_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vs_q    <= I_VSYNC;
            de_q    <= I_DE;
            pv_q    <= 1'b0;
            start_q <= 1'b0;

            // Clear first so that any set below takes priority
            if (I_CLR_ERR) begin
                err_frame_q <= 1'b0;
                err_line_q  <= 1'b0;
                overrun_q   <= 1'b0;
            end

            // A start together with a done hands the core straight over to the new window
            if (start_q)     busy_q <= 1'b1;
            else if (I_DONE) busy_q <= 1'b0;
            if (start_q && busy_q && !I_DONE) overrun_q <= 1'b1;

            // Pulse is emitted on the edge that leaves the counter at 1
            if (dly_q != '0) dly_q <= dly_q - DLY_W'(1);
            vrst_q <= (dly_q == DLY_W'(2));

            if (!I_ENABLE) begin
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
                col_q    <= '0;
                row_q    <= '0;
                dly_q    <= '0;
                vrst_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_SYNC_WAIT;
                        locked_q <= 1'b0;
                    end
                    ST_SYNC_WAIT: begin
                        locked_q <= 1'b0;
                        if (vs_rise) begin
                            state_q  <= ST_FRAME;
                            locked_q <= 1'b1;
                            col_q    <= '0;
                            row_q    <= '0;
                            dly_q    <= DLY_LOAD;
                            vrst_q   <= VRST_NOW;
                        end
                    end
                    ST_FRAME: begin
                        locked_q <= 1'b1;
                        if (vs_rise) begin
                            if (frame_done) frame_cnt_q <= frame_cnt_q + 8'd1;
                            else            err_frame_q <= 1'b1;
                            col_q  <= '0;
                            row_q  <= '0;
                            dly_q  <= DLY_LOAD;
                            vrst_q <= VRST_NOW;
                        end else if (extra_line) begin
                            state_q     <= ST_SYNC_WAIT;
                            locked_q    <= 1'b0;
                            err_frame_q <= 1'b1;
                            col_q       <= '0;
                            row_q       <= '0;
                        end else if (short_line) begin
                            state_q    <= ST_SYNC_WAIT;
                            locked_q   <= 1'b0;
                            err_line_q <= 1'b1;
                            col_q      <= '0;
                            row_q      <= '0;
                        end else if (I_DE) begin
                            pv_q    <= 1'b1;
                            col_o_q <= col_q;
                            row_o_q <= row_q;
                            // Full 3x3 window available once two rows and two columns are behind us
                            start_q <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
                            if (line_end) begin
                                col_q <= '0;
                                row_q <= row_q + ROW_W'(1);
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_COL       = col_o_q;
    assign O_ROW       = row_o_q;
    assign O_PIX_VALID = pv_q;
    assign O_START     = start_q;
    assign O_VRST      = vrst_q;
    assign O_LOCKED    = locked_q;
    assign O_FRAME_CNT = frame_cnt_q;
    assign O_ERR_FRAME = err_frame_q;
    assign O_ERR_LINE  = err_line_q;
    assign O_OVERRUN   = overrun_q;

endmodule
